// File: rtl/mcu_port_arbiter.sv
// Arbitrates the DDR controller user-request port between cache (C) and DMA (D).
// Optional cache priority with DMA starvation guard: define MCU_ARB_CACHE_PRIORITY_EN.
module mcu_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
`ifdef MCU_ARB_CACHE_PRIORITY_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic        MCU_CLK,
  input  logic        RST,
  input  logic [31:0] c_addr,
  input  logic        c_we,
  input  logic        c_req,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic        d_req,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_req,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        grant_dma
);

  localparam int unsigned DW  = 32;
  localparam int unsigned WDW = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RECOVER} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_req_q, mem_req_d;
  logic            grant_dma_q, grant_dma_d;
  logic            c_ack_q, c_ack_d, d_ack_q, d_ack_d;
  logic            c_err_q, c_err_d, d_err_q, d_err_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic            tie_dma_c;
  logic            pick_dma_c;
`ifdef MCU_ARB_CACHE_PRIORITY_EN
  logic [WDW-1:0]  starve_q, starve_d;

  // Cache wins ties until D has been passed over STARVE_LIMIT times in a row.
  assign tie_dma_c = (starve_q >= WDW'(STARVE_LIMIT));
`else
  assign tie_dma_c = rr_q;
`endif

  assign pick_dma_c = (c_req && d_req) ? tie_dma_c : d_req;

  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      wdog_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      grant_dma_q <= 1'b0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      c_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MCU_ARB_CACHE_PRIORITY_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wdog_q      <= wdog_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      grant_dma_q <= grant_dma_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      c_err_q     <= c_err_d;
      d_err_q     <= d_err_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MCU_ARB_CACHE_PRIORITY_EN
      starve_q    <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    wdog_d      = wdog_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    grant_dma_d = grant_dma_q;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_err_d     = 1'b0;
    d_err_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MCU_ARB_CACHE_PRIORITY_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (c_req || d_req) begin
          state_d     = ST_BUSY;
          grant_dma_d = pick_dma_c;
          mem_addr_d  = pick_dma_c ? d_addr : c_addr;
          mem_we_d    = pick_dma_c ? d_we : c_we;
          mem_wdata_d = pick_dma_c ? d_wdata : c_wdata;
          mem_req_d   = 1'b1;
          wdog_d      = '0;
          rr_d        = ~pick_dma_c;
`ifdef MCU_ARB_CACHE_PRIORITY_EN
          if (!pick_dma_c && d_req && (starve_q != '1)) begin
            starve_d = starve_q + WDW'(1);
          end else if (pick_dma_c || !d_req) begin
            starve_d = '0;
          end
`endif
        end
      end
      ST_BUSY: begin
        if (wdog_q != '1) begin
          wdog_d = wdog_q + WDW'(1);
        end
        // Completion beats the watchdog when both land in the same cycle.
        if (mem_ack) begin
          state_d   = ST_RECOVER;
          mem_req_d = 1'b0;
          if (grant_dma_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            c_ack_d   = 1'b1;
            c_rdata_d = mem_rdata;
          end
        end else if (wdog_q >= WDW'(TIMEOUT - 1)) begin
          state_d   = ST_RECOVER;
          mem_req_d = 1'b0;
          if (grant_dma_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            c_ack_d   = 1'b1;
            c_err_d   = 1'b1;
            c_rdata_d = '0;
          end
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_dma = grant_dma_q;
  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign c_err     = c_err_q;
  assign d_err     = d_err_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Directed bench for mcu_port_arbiter; expectations follow the build's MCU_ARB_CACHE_PRIORITY_EN setting.
module tb_mcu_port_arbiter;

  logic        MCU_CLK = 1'b0;
  logic        RST;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata, mem_rdata;
  logic        c_we, d_we, c_req, d_req, mem_ack;
  logic        c_ack, d_ack, c_err, d_err, mem_we, mem_req, grant_dma;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata;

  int n_vec = 0;
  int n_err = 0;
  logic exp_d;

  mcu_port_arbiter dut (
    .MCU_CLK   (MCU_CLK),
    .RST       (RST),
    .c_addr    (c_addr),
    .c_we      (c_we),
    .c_req     (c_req),
    .c_wdata   (c_wdata),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_req     (d_req),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_req   (mem_req),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .grant_dma (grant_dma)
  );

  always #5 MCU_CLK = ~MCU_CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge MCU_CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0; mem_rdata = '0;
    c_we = 1'b0; d_we = 1'b0; c_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

    // Reset state
    tick(2);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_c_ack", c_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_grant", grant_dma, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_c_rdata", c_rdata, 32'h0);
    RST = 1'b0;
    tick(1);

    // C read acknowledged on the third BUSY cycle
    c_addr = 32'h0000_0100; c_we = 1'b0; c_req = 1'b1;
    tick(1);
    chk1("c1_mem_req_b1", mem_req, 1'b1);
    chk32("c1_mem_addr", mem_addr, 32'h0000_0100);
    chk1("c1_mem_we", mem_we, 1'b0);
    chk1("c1_grant", grant_dma, 1'b0);
    tick(1);
    chk1("c1_mem_req_b2", mem_req, 1'b1);
    tick(1);
    chk1("c1_mem_req_b3", mem_req, 1'b1);
    chk1("c1_no_ack_yet", c_ack, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h5a5a_dada;
    tick(1);
    chk1("c1_mem_req_fall", mem_req, 1'b0);
    chk1("c1_c_ack", c_ack, 1'b1);
    chk32("c1_c_rdata", c_rdata, 32'h5a5a_dada);
    chk1("c1_d_ack", d_ack, 1'b0);
    chk1("c1_c_err", c_err, 1'b0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(1);
    c_req = 1'b0;
    chk1("c1_c_ack_drop", c_ack, 1'b0);
    chk32("c1_c_rdata_hold", c_rdata, 32'h5a5a_dada);
    tick(1);

    // Stray mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick(1);
    chk1("idle_ack_c", c_ack, 1'b0);
    chk1("idle_ack_d", d_ack, 1'b0);
    chk1("idle_ack_req", mem_req, 1'b0);
    mem_ack = 1'b0;
    tick(1);
    chk1("idle_ack_req2", mem_req, 1'b0);

    // D read acknowledged on the first BUSY cycle
    d_addr = 32'h0000_0080; d_we = 1'b0; d_req = 1'b1;
    tick(1);
    chk1("d1_mem_req", mem_req, 1'b1);
    chk1("d1_grant", grant_dma, 1'b1);
    chk32("d1_mem_addr", mem_addr, 32'h0000_0080);
    mem_ack = 1'b1; mem_rdata = 32'hcafe_f00d;
    tick(1);
    chk1("d1_d_ack", d_ack, 1'b1);
    chk32("d1_d_rdata", d_rdata, 32'hcafe_f00d);
    chk1("d1_c_ack", c_ack, 1'b0);
    chk1("d1_mem_req_fall", mem_req, 1'b0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(1);
    d_req = 1'b0;
    chk1("d1_d_ack_drop", d_ack, 1'b0);
    chk32("d1_c_rdata_hold", c_rdata, 32'h5a5a_dada);
    tick(1);

    // D write with no acknowledge: watchdog abort after 255 BUSY cycles
    d_addr = 32'h0000_0400; d_we = 1'b1; d_wdata = 32'h5a5a_0000; d_req = 1'b1;
    tick(1);
    chk1("to_mem_req", mem_req, 1'b1);
    chk1("to_mem_we", mem_we, 1'b1);
    chk32("to_mem_addr", mem_addr, 32'h0000_0400);
    chk32("to_mem_wdata", mem_wdata, 32'h5a5a_0000);
    chk1("to_grant", grant_dma, 1'b1);
    tick(254);
    chk1("to_mem_req_254", mem_req, 1'b1);
    chk1("to_no_ack_254", d_ack, 1'b0);
    tick(1);
    chk1("to_mem_req_fall", mem_req, 1'b0);
    chk1("to_d_ack", d_ack, 1'b1);
    chk1("to_d_err", d_err, 1'b1);
    chk32("to_d_rdata", d_rdata, 32'h0);
    chk1("to_c_ack", c_ack, 1'b0);
    tick(1);
    d_req = 1'b0; d_we = 1'b0;
    chk1("to_d_ack_drop", d_ack, 1'b0);
    chk1("to_d_err_drop", d_err, 1'b0);
    tick(1);

    // Reset during BUSY drops mem_req at once with no ack
    c_addr = 32'h0000_0200; c_req = 1'b1;
    tick(1);
    chk1("rb_mem_req", mem_req, 1'b1);
    tick(1);
    RST = 1'b1; c_req = 1'b0;
    #1;
    chk1("rb_mem_req_async", mem_req, 1'b0);
    chk1("rb_c_ack", c_ack, 1'b0);
    tick(2);
    chk1("rb_c_ack_held", c_ack, 1'b0);
    chk1("rb_grant", grant_dma, 1'b0);
    RST = 1'b0;

    // Both requesters continuously requesting; controller acks immediately
    c_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    c_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef MCU_ARB_CACHE_PRIORITY_EN
      exp_d = ((i % 5) == 4);
`else
      exp_d = ((i % 2) == 1);
`endif
      tick(1);
      chk1("arb_grant", grant_dma, exp_d);
      chk32("arb_addr", mem_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
      tick(1);
      chk1("arb_c_ack", c_ack, ~exp_d);
      chk1("arb_d_ack", d_ack, exp_d);
      tick(1);
    end
    c_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick(2);
    chk1("end_mem_req", mem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
